// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle SLL/SRL/SRA unit for the ALU path. A single small shifter
// (one STEP-bit stage plus one 1-bit stage) is applied iteratively, so no
// full barrel shifter is needed. Decode issues a request, EX stalls on
// busy_o until the one-cycle done_o pulse.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   start_i    request, sampled only while idle
//   op_i       00=SLL, 01=SRL, 10=SRA, 11=pass-through
//   operand_i  value to shift, captured on accept
//   shamt_i    shift amount 0..31, captured on accept
//   flush_i    synchronous abort (wins over start and over completion)
//   busy_o     high while an operation is in flight
//   done_o     one-cycle completion pulse
//   result_o   shifted value, held until the next completion
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int unsigned STEP  = 4,   // 2, 4, 8 or 16
    parameter int unsigned WIDTH = 32   // fixed datapath width
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] operand_i,
    input  logic [4:0]       shamt_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic [4:0]       step_amt;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= OP_SLL;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;     // done is a single-cycle pulse
        step_amt = 5'd1;

        if (flush_i) begin
            // Abort: drop any accept or completion; result keeps last value.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        acc_d   = operand_i;
                        // Pass-through completes as a zero-length shift.
                        cnt_d   = (op_i == OP_PASS) ? 5'd0 : shamt_i;
                        op_d    = op_i;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == 5'd0) begin
                        result_d = acc_q;
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        // Coarse stage while enough distance remains, then
                        // finish with single-bit steps.
                        step_amt = (cnt_q >= STEP_AMT) ? STEP_AMT : 5'd1;
                        cnt_d    = cnt_q - step_amt;
                        case (op_q)
                            OP_SLL:  acc_d = acc_q << step_amt;
                            OP_SRL:  acc_d = acc_q >> step_amt;
                            // Arithmetic shift re-fills with bit 31, so the
                            // sign propagates across every iteration.
                            OP_SRA:  acc_d = $signed(acc_q) >>> step_amt;
                            default: acc_d = acc_q;
                        endcase
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q == S_SHIFT);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
